// File: rtl/shift_tx_ctrl_pkg.sv
// Shared types and defaults for the serial transmit sequencer and its shift datapath.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/shift_tx_ctrl_if.sv
// Producer-facing handshake plus serial-side outputs of the transmit sequencer.
interface shift_tx_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             en_i;
    logic             ser_o;
    logic             ser_valid_o;
    logic             frame_o;
    logic             busy_o;
    logic             done_o;

    // The controller is the slave: it consumes words and produces the serial stream.
    modport slave (
        input  data_i,
        input  valid_i,
        input  en_i,
        output ready_o,
        output ser_o,
        output ser_valid_o,
        output frame_o,
        output busy_o,
        output done_o
    );

    modport master (
        output data_i,
        output valid_i,
        output en_i,
        input  ready_o,
        input  ser_o,
        input  ser_valid_o,
        input  frame_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/shift_tx_ctrl_core.sv
// Loadable parallel-in/serial-out register; a load beats a shift in the same cycle.
module shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] sr_o
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load_i) begin
            sr <= d_i;
        end else if (shift_i) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign sr_o = sr;

endmodule

// File: rtl/shift_tx_ctrl.sv
// Frame sequencer: accepts a word, shifts it out MSB-first under en_i, then holds an idle gap.
module shift_tx_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP
) (
    input  logic           clk,
    input  logic           reset,
    shift_tx_ctrl_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       gap_cnt;
    logic [3:0]       gap_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             load;
    logic             shift;
    logic             accept;
    logic             in_shift;
    logic [WIDTH-1:0] sr;
    logic             unused_sr_low;

    shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .d_i    (bus.data_i),
        .shift_i(shift),
        .sr_o   (sr)
    );

    // Only the MSB leaves the block; the lower bits just ride along inside the core.
    assign unused_sr_low = ^sr[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            done_q  <= done_nxt;
        end
    end

    assign accept = bus.valid_i && bus.ready_o;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    cnt_nxt   = CNT_LAST;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en_i) begin
                    shift = 1'b1;
                    if (cnt == '0) begin
                        done_nxt = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_nxt = GAP;
                            gap_nxt   = GAP_LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            GAP: begin
                // gap_cnt counts the remaining idle cycles after this one.
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are gated by reset so nothing leaks while reset is held.
    assign in_shift        = (state == SHIFT) && !reset;
    assign bus.ready_o     = (state == IDLE) && !reset;
    assign bus.busy_o      = (state != IDLE) && !reset;
    assign bus.ser_o       = in_shift && sr[WIDTH-1];
    assign bus.ser_valid_o = in_shift && bus.en_i;
    assign bus.frame_o     = in_shift && bus.en_i && (cnt == CNT_LAST);
    assign bus.done_o      = done_q;

endmodule
